// File: rtl/mastermind_turn_ctrl.sv
// mastermind_turn_ctrl
//
// Purpose: turn and scoring controller for a Mastermind game. The player
// edits a 4-peg guess with single-cycle button pulses. Submitting starts a
// multi-cycle sequential scorer against the latched secret. After scoring,
// the controller advances the turn or ends the game as a win or a loss.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   secret[11:0]        secret code, peg i = secret[3i+2:3i]
//   secret_valid        pulse: latch secret and start a new game
//   btnL/btnR           cursor left / right
//   btnU/btnD           colour up / down at the cursor
//   btnS                submit guess (or leave WIN/LOSE)
//   rgb0_out..rgb3_out  current guess colours of pegs 0..3
//   cursor[1:0]         peg being edited
//   turn_led            one-hot current turn (all zero in IDLE)
//   exact, partial      result of the last scored guess
//   score_valid         one-cycle pulse while a new result is presented
//   busy                high while scoring (SCORE_X, SCORE_P, RESULT)
//   win, lose           game-over flags
module mastermind_turn_ctrl #(
  parameter int NUM_TURNS  = 8,
  parameter int NUM_COLORS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [11:0]          secret,
  input  logic                 secret_valid,
  input  logic                 btnL,
  input  logic                 btnR,
  input  logic                 btnU,
  input  logic                 btnD,
  input  logic                 btnS,
  output logic [2:0]           rgb0_out,
  output logic [2:0]           rgb1_out,
  output logic [2:0]           rgb2_out,
  output logic [2:0]           rgb3_out,
  output logic [1:0]           cursor,
  output logic [NUM_TURNS-1:0] turn_led,
  output logic [2:0]           exact,
  output logic [2:0]           partial,
  output logic                 score_valid,
  output logic                 busy,
  output logic                 win,
  output logic                 lose
);

  localparam logic [2:0]           COLOR_MAX = 3'(NUM_COLORS - 1);
  localparam logic [2:0]           LAST_TURN = 3'(NUM_TURNS - 1);
  localparam logic [NUM_TURNS-1:0] FIRST_LED = NUM_TURNS'(1);

  typedef enum logic [2:0] {
    IDLE,
    EDIT,
    SCORE_X,
    SCORE_P,
    RESULT,
    WIN,
    LOSE
  } state_t;

  state_t     state;
  logic [2:0] secret_peg [4];
  logic [2:0] guess [4];
  logic [2:0] turn;
  logic [1:0] idx;
  logic [2:0] color;
  logic [2:0] exact_acc;
  logic [2:0] total_acc;
  logic [2:0] guess_cnt;
  logic [2:0] secret_cnt;
  logic [2:0] min_cnt;

  // Out-of-range secret pegs can never be matched by a legal guess colour,
  // so they are folded to colour 0 when latched.
  function automatic logic [2:0] legal_color(input logic [2:0] peg);
    return (int'(peg) >= NUM_COLORS) ? 3'd0 : peg;
  endfunction

  // Occurrences of the colour currently visited by SCORE_P in the guess
  // and in the secret; their minimum is that colour's contribution to the
  // total (exact + partial) match count.
  always_comb begin
    guess_cnt  = '0;
    secret_cnt = '0;
    for (int j = 0; j < 4; j++) begin
      if (guess[j] == color)      guess_cnt  = guess_cnt + 3'd1;
      if (secret_peg[j] == color) secret_cnt = secret_cnt + 3'd1;
    end
    min_cnt = (guess_cnt < secret_cnt) ? guess_cnt : secret_cnt;
  end

  // Main controller. secret_valid overrides every state. The result is
  // loaded on the last SCORE_P edge so exact/partial and score_valid are
  // all visible during the RESULT cycle, and RESULT can then branch on
  // the registered exact count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      for (int j = 0; j < 4; j++) begin
        secret_peg[j] <= '0;
        guess[j]      <= '0;
      end
      turn        <= '0;
      cursor      <= '0;
      turn_led    <= '0;
      idx         <= '0;
      color       <= '0;
      exact_acc   <= '0;
      total_acc   <= '0;
      exact       <= '0;
      partial     <= '0;
      score_valid <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      if (secret_valid) begin
        for (int j = 0; j < 4; j++) begin
          secret_peg[j] <= legal_color(secret[3*j +: 3]);
          guess[j]      <= '0;
        end
        turn     <= '0;
        cursor   <= '0;
        turn_led <= FIRST_LED;
        exact    <= '0;
        partial  <= '0;
        state    <= EDIT;
      end else begin
        case (state)
          IDLE: begin
          end
          EDIT: begin
            if (btnS) begin
              idx       <= '0;
              color     <= '0;
              exact_acc <= '0;
              total_acc <= '0;
              state     <= SCORE_X;
            end else if (btnU) begin
              guess[cursor] <= (guess[cursor] == COLOR_MAX) ? 3'd0 : guess[cursor] + 3'd1;
            end else if (btnD) begin
              guess[cursor] <= (guess[cursor] == 3'd0) ? COLOR_MAX : guess[cursor] - 3'd1;
            end else if (btnL) begin
              cursor <= cursor - 2'd1;
            end else if (btnR) begin
              cursor <= cursor + 2'd1;
            end
          end
          SCORE_X: begin
            if (guess[idx] == secret_peg[idx]) exact_acc <= exact_acc + 3'd1;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              color <= '0;
              state <= SCORE_P;
            end
          end
          SCORE_P: begin
            if (color == COLOR_MAX) begin
              exact       <= exact_acc;
              partial     <= total_acc + min_cnt - exact_acc;
              score_valid <= 1'b1;
              state       <= RESULT;
            end else begin
              total_acc <= total_acc + min_cnt;
              color     <= color + 3'd1;
            end
          end
          RESULT: begin
            if (exact == 3'd4) begin
              state <= WIN;
            end else if (turn == LAST_TURN) begin
              state <= LOSE;
            end else begin
              turn     <= turn + 3'd1;
              turn_led <= turn_led << 1;
              state    <= EDIT;
            end
          end
          WIN, LOSE: begin
            if (btnS) begin
              for (int j = 0; j < 4; j++) guess[j] <= '0;
              turn     <= '0;
              cursor   <= '0;
              turn_led <= '0;
              exact    <= '0;
              partial  <= '0;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign rgb0_out = guess[0];
  assign rgb1_out = guess[1];
  assign rgb2_out = guess[2];
  assign rgb3_out = guess[3];
  assign busy     = (state == SCORE_X) || (state == SCORE_P) || (state == RESULT);
  assign win      = (state == WIN);
  assign lose     = (state == LOSE);

endmodule

// File: tb/tb_mastermind_turn_ctrl.sv
// tb_mastermind_turn_ctrl
//
// Bench for mastermind_turn_ctrl. A behavioural game model (guess/secret
// arrays, a coarse game mode and a cycle timer since submit) predicts every
// output; one compare process checks all outputs against it on every
// falling edge. Directed game scenarios add literal expectations, and a
// long randomized phase exercises button priorities, aborts and restarts.
module tb_mastermind_turn_ctrl;

  localparam int NT = 8;
  localparam int NC = 6;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_S    = 5'b10000;
  localparam logic [4:0] B_U    = 5'b01000;
  localparam logic [4:0] B_D    = 5'b00100;
  localparam logic [4:0] B_L    = 5'b00010;
  localparam logic [4:0] B_R    = 5'b00001;

  localparam int MD_IDLE = 0;
  localparam int MD_EDIT = 1;
  localparam int MD_BUSY = 2;
  localparam int MD_WIN  = 3;
  localparam int MD_LOSE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [11:0]   secret = '0;
  logic          secret_valid = 1'b0;
  logic          btnL = 1'b0, btnR = 1'b0, btnU = 1'b0, btnD = 1'b0, btnS = 1'b0;
  logic [2:0]    rgb0_out, rgb1_out, rgb2_out, rgb3_out;
  logic [1:0]    cursor;
  logic [NT-1:0] turn_led;
  logic [2:0]    exact, partial;
  logic          score_valid, busy, win, lose;

  int vectors = 0;
  int miscompares = 0;
  logic cmp_en = 1'b0;

  // behavioural model state
  int m_mode;
  int m_secret [4];
  int m_guess [4];
  int m_cursor, m_turn, m_exact, m_partial, m_timer;
  int m_pend_exact, m_pend_partial;
  logic m_sv;

  mastermind_turn_ctrl #(.NUM_TURNS(NT), .NUM_COLORS(NC)) dut (
    .clk(clk), .rst_n(rst_n), .secret(secret), .secret_valid(secret_valid),
    .btnL(btnL), .btnR(btnR), .btnU(btnU), .btnD(btnD), .btnS(btnS),
    .rgb0_out(rgb0_out), .rgb1_out(rgb1_out), .rgb2_out(rgb2_out), .rgb3_out(rgb3_out),
    .cursor(cursor), .turn_led(turn_led), .exact(exact), .partial(partial),
    .score_valid(score_valid), .busy(busy), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] sec4(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  // Mastermind scoring from first principles: exact = same colour same
  // position; total = sum over colours of min occurrences; partial = rest.
  function automatic logic [5:0] mmScore(input logic [11:0] s, input logic [11:0] g);
    int ex, tot;
    int cs [8];
    int cg [8];
    ex = 0;
    tot = 0;
    for (int c = 0; c < 8; c++) begin
      cs[c] = 0;
      cg[c] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (s[3*i +: 3] == g[3*i +: 3]) ex++;
      cs[s[3*i +: 3]]++;
      cg[g[3*i +: 3]]++;
    end
    for (int c = 0; c < 8; c++) tot += (cs[c] < cg[c]) ? cs[c] : cg[c];
    return {3'(ex), 3'(tot - ex)};
  endfunction

  task automatic modelReset();
    m_mode = MD_IDLE;
    for (int j = 0; j < 4; j++) begin
      m_secret[j] = 0;
      m_guess[j]  = 0;
    end
    m_cursor = 0; m_turn = 0; m_exact = 0; m_partial = 0; m_timer = 0;
    m_pend_exact = 0; m_pend_partial = 0; m_sv = 1'b0;
  endtask

  task automatic modelStep();
    logic [5:0] sc;
    m_sv = 1'b0;
    if (secret_valid) begin
      for (int j = 0; j < 4; j++) begin
        m_secret[j] = (int'(secret[3*j +: 3]) >= NC) ? 0 : int'(secret[3*j +: 3]);
        m_guess[j]  = 0;
      end
      m_turn = 0; m_cursor = 0; m_exact = 0; m_partial = 0;
      m_mode = MD_EDIT;
    end else begin
      case (m_mode)
        MD_EDIT: begin
          if (btnS) begin
            sc = mmScore(sec4(m_secret[0], m_secret[1], m_secret[2], m_secret[3]),
                         sec4(m_guess[0], m_guess[1], m_guess[2], m_guess[3]));
            m_pend_exact = int'(sc[5:3]);
            m_pend_partial = int'(sc[2:0]);
            m_timer = 1;
            m_mode = MD_BUSY;
          end else if (btnU) m_guess[m_cursor] = (m_guess[m_cursor] + 1) % NC;
          else if (btnD) m_guess[m_cursor] = (m_guess[m_cursor] + NC - 1) % NC;
          else if (btnL) m_cursor = (m_cursor + 3) % 4;
          else if (btnR) m_cursor = (m_cursor + 1) % 4;
        end
        MD_BUSY: begin
          m_timer++;
          if (m_timer == 5 + NC) begin
            m_sv = 1'b1;
            m_exact = m_pend_exact;
            m_partial = m_pend_partial;
          end else if (m_timer == 6 + NC) begin
            if (m_exact == 4) m_mode = MD_WIN;
            else if (m_turn == NT - 1) m_mode = MD_LOSE;
            else begin
              m_turn++;
              m_mode = MD_EDIT;
            end
          end
        end
        MD_WIN, MD_LOSE: begin
          if (btnS) begin
            for (int j = 0; j < 4; j++) m_guess[j] = 0;
            m_cursor = 0; m_turn = 0; m_exact = 0; m_partial = 0;
            m_mode = MD_IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("rgb0", 32'(rgb0_out), 32'(m_guess[0]));
    checkOutput("rgb1", 32'(rgb1_out), 32'(m_guess[1]));
    checkOutput("rgb2", 32'(rgb2_out), 32'(m_guess[2]));
    checkOutput("rgb3", 32'(rgb3_out), 32'(m_guess[3]));
    checkOutput("cursor", 32'(cursor), 32'(m_cursor));
    checkOutput("turn_led", 32'(turn_led), (m_mode == MD_IDLE) ? 32'd0 : (32'd1 << m_turn));
    checkOutput("exact", 32'(exact), 32'(m_exact));
    checkOutput("partial", 32'(partial), 32'(m_partial));
    checkOutput("score_valid", 32'(score_valid), 32'(m_sv));
    checkOutput("busy", 32'(busy), 32'(m_mode == MD_BUSY));
    checkOutput("win", 32'(win), 32'(m_mode == MD_WIN));
    checkOutput("lose", 32'(lose), 32'(m_mode == MD_LOSE));
  endtask

  // model follows the DUT's clock and asynchronous reset
  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  // single compare process, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) compareAll();
    end
  end

  task automatic applyStimulus(input logic sv, input logic [11:0] sec, input logic [4:0] b);
    @(negedge clk);
    secret_valid = sv;
    secret = sec;
    {btnS, btnU, btnD, btnL, btnR} = b;
  endtask

  task automatic newGame(input logic [11:0] sec);
    applyStimulus(1'b1, sec, B_NONE);
    applyStimulus(1'b0, '0, B_NONE);
  endtask

  // Navigate to a target guess using only btnR and btnU, planned from the
  // model's settled view (the pending input is an idle cycle).
  task automatic enterGuess(input int g0, input int g1, input int g2, input int g3);
    int tgt [4];
    int cur, n;
    tgt[0] = g0; tgt[1] = g1; tgt[2] = g2; tgt[3] = g3;
    applyStimulus(1'b0, '0, B_NONE);
    cur = m_cursor;
    for (int p = 0; p < 4; p++) begin
      n = (p - cur + 4) % 4;
      for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, B_R);
      cur = p;
      n = (tgt[p] - m_guess[p] + NC) % NC;
      for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, B_U);
    end
    applyStimulus(1'b0, '0, B_NONE);
  endtask

  // Submit and wait (bounded) for score_valid while hammering buttons that
  // must be ignored; checks the submit-to-score latency.
  task automatic submitAndWait();
    int n;
    n = 0;
    applyStimulus(1'b0, '0, B_S);
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(1'b0, '0, 5'($urandom_range(0, 31)));
      if (score_valid === 1'b1) begin
        n = i;
        break;
      end
    end
    checkOutput("score_latency", 32'(n), 32'(5 + NC));
  endtask

  initial begin
    logic [4:0] b;
    logic sv;
    int pulses;

    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] b;
    logic sv;
    int pulses;

    // model pinning: scoring rule on hand-computed cases
    checkOutput("model_win", 32'(mmScore(sec4(1,2,3,4), sec4(1,2,3,4))), 32'({3'd4, 3'd0}));
    checkOutput("model_swap", 32'(mmScore(sec4(0,0,1,1), sec4(1,1,0,0))), 32'({3'd0, 3'd4}));
    checkOutput("model_dup", 32'(mmScore(sec4(2,2,2,2), sec4(2,0,0,0))), 32'({3'd1, 3'd0}));
    checkOutput("model_rev", 32'(mmScore(sec4(1,2,3,4), sec4(4,3,2,1))), 32'({3'd0, 3'd4}));

    // reset
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_turn_led", 32'(turn_led), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    #2 rst_n = 1'b1;

    // IDLE ignores buttons
    applyStimulus(1'b0, '0, B_S | B_U);
    applyStimulus(1'b0, '0, B_NONE);
    checkOutput("idle_ignore_busy", 32'(busy), 32'd0);
    checkOutput("idle_ignore_rgb0", 32'(rgb0_out), 32'd0);

    // win in one turn, with wrap-around and priority checks on the way
    newGame(sec4(1,2,3,4));
    checkOutput("new_turn_led", 32'(turn_led), 32'h01);
    applyStimulus(1'b0, '0, B_D); applyStimulus(1'b0, '0, B_NONE);
    checkOutput("wrap_down", 32'(rgb0_out), 32'd5);
    applyStimulus(1'b0, '0, B_U); applyStimulus(1'b0, '0, B_NONE);
    checkOutput("wrap_up", 32'(rgb0_out), 32'd0);
    applyStimulus(1'b0, '0, B_L); applyStimulus(1'b0, '0, B_NONE);
    checkOutput("wrap_left", 32'(cursor), 32'd3);
    applyStimulus(1'b0, '0, B_R); applyStimulus(1'b0, '0, B_NONE);
    checkOutput("wrap_right", 32'(cursor), 32'd0);
    applyStimulus(1'b0, '0, B_U | B_L); applyStimulus(1'b0, '0, B_NONE);
    checkOutput("prio_u_color", 32'(rgb0_out), 32'd1);
    checkOutput("prio_u_cursor", 32'(cursor), 32'd0);
    enterGuess(1, 2, 3, 4);
    submitAndWait();
    checkOutput("win_exact", 32'(exact), 32'd4);
    checkOutput("win_partial", 32'(partial), 32'd0);
    applyStimulus(1'b0, '0, B_NONE);
    checkOutput("win_flag", 32'(win), 32'd1);
    checkOutput("win_turn_led", 32'(turn_led), 32'h01);
    applyStimulus(1'b0, '0, B_S); applyStimulus(1'b0, '0, B_NONE);
    checkOutput("win_exit_led", 32'(turn_led), 32'd0);
    checkOutput("win_exit_rgb3", 32'(rgb3_out), 32'd0);

    // partial scoring
    newGame(sec4(0,0,1,1));
    enterGuess(1, 1, 0, 0);
    submitAndWait();
    checkOutput("swap_exact", 32'(exact), 32'd0);
    checkOutput("swap_partial", 32'(partial), 32'd4);
    applyStimulus(1'b0, '0, B_NONE);
    checkOutput("swap_turn_led", 32'(turn_led), 32'h02);
    newGame(sec4(2,2,2,2));
    enterGuess(2, 0, 0, 0);
    submitAndWait();
    checkOutput("dup_exact", 32'(exact), 32'd1);
    checkOutput("dup_partial", 32'(partial), 32'd0);
    applyStimulus(1'b0, '0, B_NONE);

    // secret_valid during SCORE_X aborts scoring
    applyStimulus(1'b0, '0, B_S);
    applyStimulus(1'b0, '0, B_NONE);
    applyStimulus(1'b0, '0, B_NONE);
    applyStimulus(1'b1, sec4(3,3,3,3), B_NONE);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, '0, B_NONE);
      if (score_valid === 1'b1) pulses++;
    end
    checkOutput("abort_pulses", 32'(pulses), 32'd0);
    checkOutput("abort_turn_led", 32'(turn_led), 32'h01);

    // reset during SCORE_P
    applyStimulus(1'b0, '0, B_S);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, B_NONE);
    checkOutput("busy_before_reset", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_led", 32'(turn_led), 32'd0);
    checkOutput("midrst_cursor", 32'(cursor), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(1'b0, '0, B_S); applyStimulus(1'b0, '0, B_NONE);
    checkOutput("postrst_ignore", 32'(busy), 32'd0);

    // out-of-range secret pegs fold to colour 0
    newGame(sec4(7,6,1,0));
    enterGuess(0, 0, 1, 0);
    submitAndWait();
    checkOutput("fold_exact", 32'(exact), 32'd4);
    applyStimulus(1'b0, '0, B_S); applyStimulus(1'b0, '0, B_NONE);

    // lose after NT wrong guesses
    newGame(sec4(5,5,5,5));
    for (int t = 0; t < NT; t++) submitAndWait();
    applyStimulus(1'b0, '0, B_NONE);
    checkOutput("lose_flag", 32'(lose), 32'd1);
    checkOutput("lose_turn_led", 32'(turn_led), 32'h80);
    applyStimulus(1'b0, '0, B_U); applyStimulus(1'b0, '0, B_NONE);
    checkOutput("lose_hold", 32'(lose), 32'd1);
    applyStimulus(1'b0, '0, B_S); applyStimulus(1'b0, '0, B_NONE);
    checkOutput("lose_exit", 32'(lose), 32'd0);
    checkOutput("lose_exit_led", 32'(turn_led), 32'd0);

    // randomized play, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      sv = ($urandom_range(0, 79) == 0) || (m_mode == MD_IDLE && $urandom_range(0, 5) == 0);
      b = {($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 2) == 0) b[3:0] = 4'b0000;
      applyStimulus(sv, 12'($urandom_range(0, 4095)), b);
    end
    applyStimulus(1'b0, '0, B_NONE);
    applyStimulus(1'b0, '0, B_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mastermind_turn_ctrl.md
# mastermind_turn_ctrl

Turn and scoring controller for the Mastermind game. It takes single-cycle, pre-debounced button pulses and lets the player edit a 4-peg guess. On submit it scores the guess against the latched secret with a multi-cycle sequential scorer. It then advances the turn, or ends the game as win or lose. It drives the RGB peg outputs and the one-hot turn LEDs of the top level.

## Interface
- NUM_TURNS, 8, guesses allowed per game; also the width of turn_led (2..8).
- NUM_COLORS, 6, legal peg colours 0..NUM_COLORS-1 (2..8).
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- secret  in  12  secret code; peg i = secret[3i+2:3i].
- secret_valid  in  1  single-cycle pulse that loads the secret and starts a new game.
- btnL, btnR, btnU, btnD, btnS  in  1 each  single-cycle pulses:
  - btnL / btnR: cursor left / right.
  - btnU / btnD: colour up / down.
  - btnS: submit.
- rgb0_out..rgb3_out  out  3 each  current guess colour of pegs 0..3.
- cursor  out  2  index of the peg being edited.
- turn_led  out  NUM_TURNS  one-hot current turn.
- exact  out  3  pegs with correct colour and position (0..4), last scored guess.
- partial  out  3  pegs with correct colour but wrong position (0..4), last scored guess.
- score_valid  out  1  one-cycle pulse when exact/partial update.
- busy  out  1  high while scoring.
- win, lose  out  1 each  game-over flags.

## Operation
- States: IDLE, EDIT, SCORE_X, SCORE_P, RESULT, WIN, LOSE.
- Reset (async, any time): state IDLE. Every output is 0, including turn_led, exact, partial and all rgb outputs. Internal counters are cleared.
- secret_valid has the highest priority in every state. It is handled the same way from any state:
  - Latch secret; a peg value >= NUM_COLORS is stored as 0.
  - Set turn=0, cursor=0 and all guess pegs to 0.
  - Clear exact, partial, win and lose.
  - Go to EDIT.
- IDLE: buttons are ignored.
- EDIT: turn_led = 1<<turn. At most one action per cycle, priority btnS > btnU > btnD > btnL > btnR:
  - btnU: guess[cursor]+1, wrapping NUM_COLORS-1 -> 0.
  - btnD: guess[cursor]-1, wrapping 0 -> NUM_COLORS-1.
  - btnL: cursor-1 mod 4.
  - btnR: cursor+1 mod 4.
  - btnS: clear the scoring accumulators and go to SCORE_X.
- SCORE_X: 4 cycles with index i=0..3. The exact accumulator increments when guess[i]==secret[i].
- SCORE_P: NUM_COLORS cycles with colour c=0..NUM_COLORS-1. The total accumulator adds min(count of c in guess, count of c in secret). The counts are combinational over 4 pegs, each 0..4.
- RESULT: 1 cycle.
  - exact <= exact accumulator; partial <= total - exact accumulator (3-bit, never negative).
  - score_valid=1.
  - Next state, checked in this order:
    - exact==4 -> WIN.
    - Else turn==NUM_TURNS-1 -> LOSE.
    - Else turn+1 and go to EDIT. The guess and cursor are retained.
- WIN / LOSE:
  - win or lose is held at 1, and turn_led holds the final turn.
  - The guess, exact and partial are held.
  - btnS returns to IDLE and clears all outputs to their reset values. Other buttons are ignored.
- Buttons during SCORE_X, SCORE_P and RESULT are ignored and are not queued.
- busy=1 exactly in SCORE_X, SCORE_P and RESULT.

## Timing
- Button and secret_valid effects are visible on the outputs the cycle after the sampling edge.
- Scoring latency, counting from the edge that samples btnS in EDIT:
  - SCORE_X occupies cycles k+1..k+4.
  - SCORE_P occupies cycles k+5..k+4+NUM_COLORS.
  - score_valid is high in cycle k+5+NUM_COLORS, which is k+11 at the default.
- The first btnS accepted after RESULT is the one sampled in EDIT, one cycle after score_valid.
- secret_valid during scoring aborts the scoring: no score_valid pulse and a fresh EDIT.
- rst_n deassertion is synchronised externally. The first accepted input is at the first edge with rst_n=1.

## Test plan
- Reset mid-scoring: assert rst_n=0 during SCORE_P -> all outputs 0 immediately and state IDLE. btnS is then ignored until secret_valid.
- Win in one turn:
  - Stimulus: secret pegs 1,2,3,4. Enter the guess 1,2,3,4 using btnU and btnR, then btnS.
  - Response: score_valid 11 cycles after btnS, exact=4, partial=0, win=1, turn_led=8'b00000001.
- Partial scoring:
  - Secret 0,0,1,1 with guess 1,1,0,0 -> exact=0, partial=4, turn_led advances to 8'b00000010.
  - Secret 2,2,2,2 with guess 2,0,0,0 -> exact=1, partial=0.
- Wrap-around:
  - btnD on colour 0 -> 5; btnU on colour 5 -> 0.
  - btnL at cursor 0 -> 3; btnR at cursor 3 -> 0.
- Lose: 8 consecutive wrong guesses -> lose=1 after the 8th score_valid, with turn_led=8'b10000000. btnS then returns to IDLE with all outputs 0.
- Simultaneous events:
  - btnU and btnL in the same cycle -> only the colour increments.
  - secret_valid during SCORE_X -> no score_valid pulse, EDIT with turn=0.
  - Buttons pressed during busy have no effect.
